led_data_sel: RTL

//  Produces the 32-bit Leddata word consumed by the 8-digit seven-segment display driver.

---
 rtl/led_data_sel.sv | 131 +++++++++++++
 1 files changed

// File: rtl/led_data_sel.sv
// rtl/led_data_sel.sv - statistics counters, syscall latch, debounced mode select and Leddata mux
// Mode advances on each debounced button press; Leddata is the registered view of the selected source.
module led_data_sel #(
  parameter int DEBOUNCE_CYCLES = 1_000_000
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        cyc_en,
  input  logic        halt,
  input  logic        is_jump,
  input  logic        is_branch,
  input  logic        branch_taken,
  input  logic        syscall_show,
  input  logic [31:0] a0_val,
  input  logic [31:0] pc,
  input  logic        btn_mode,
  output logic [31:0] Leddata,
  output logic [2:0]  mode
);

  localparam int DB_W = (DEBOUNCE_CYCLES > 2) ? $clog2(DEBOUNCE_CYCLES) : 1;
  localparam logic [DB_W-1:0] DB_LAST = DB_W'(DEBOUNCE_CYCLES - 1);

  typedef enum logic [2:0] {
    S_SYS = 3'd0,
    S_CYC = 3'd1,
    S_JMP = 3'd2,
    S_BR  = 3'd3,
    S_TKN = 3'd4,
    S_PC  = 3'd5
  } state_t;

  state_t            state;
  logic [31:0]       cyc_cnt;
  logic [31:0]       jmp_cnt;
  logic [31:0]       br_cnt;
  logic [31:0]       tkn_cnt;
  logic [31:0]       sys_reg;
  logic              btn_s1;
  logic              btn_s2;
  logic              deb_level;
  logic [DB_W-1:0]   deb_cnt;
  logic              cnt_en;
  logic              deb_flip;
  logic              deb_rise;

  always_comb begin
    cnt_en   = cyc_en & ~halt;
    deb_flip = (btn_s2 != deb_level) && (deb_cnt == DB_LAST);
    deb_rise = deb_flip & ~deb_level;
  end

  // Counters add 0 or 1 every cycle so the register is always rewritten from its current value.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      cyc_cnt <= '0;
      jmp_cnt <= '0;
      br_cnt  <= '0;
      tkn_cnt <= '0;
    end else begin
      cyc_cnt <= cyc_cnt + 32'(cnt_en);
      jmp_cnt <= jmp_cnt + 32'(cnt_en & is_jump);
      br_cnt  <= br_cnt  + 32'(cnt_en & is_branch);
      tkn_cnt <= tkn_cnt + 32'(cnt_en & is_branch & branch_taken);
    end
  end

  // The display syscall must still be visible once the CPU has halted.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      sys_reg <= '0;
    end else if (cyc_en && syscall_show) begin
      sys_reg <= a0_val;
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      btn_s1    <= 1'b0;
      btn_s2    <= 1'b0;
      deb_level <= 1'b0;
      deb_cnt   <= '0;
    end else begin
      btn_s1 <= btn_mode;
      btn_s2 <= btn_s1;
      if (btn_s2 == deb_level) begin
        deb_cnt <= '0;
      end else if (deb_flip) begin
        deb_cnt   <= '0;
        deb_level <= ~deb_level;
      end else begin
        deb_cnt <= deb_cnt + 1'b1;
      end
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state <= S_SYS;
    end else begin
      case (state)
        S_SYS:   if (deb_rise) state <= S_CYC;
        S_CYC:   if (deb_rise) state <= S_JMP;
        S_JMP:   if (deb_rise) state <= S_BR;
        S_BR:    if (deb_rise) state <= S_TKN;
        S_TKN:   if (deb_rise) state <= S_PC;
        S_PC:    if (deb_rise) state <= S_SYS;
        default: state <= S_SYS;
      endcase
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      Leddata <= '0;
    end else begin
      case (state)
        S_SYS:   Leddata <= sys_reg;
        S_CYC:   Leddata <= cyc_cnt;
        S_JMP:   Leddata <= jmp_cnt;
        S_BR:    Leddata <= br_cnt;
        S_TKN:   Leddata <= tkn_cnt;
        S_PC:    Leddata <= pc;
        default: Leddata <= '0;
      endcase
    end
  end

  assign mode = state;

endmodule
